// File: rtl/alu_mdu_iter_if.sv
// rtl/alu_mdu_iter_if.sv - issue/completion handshake bundle for the iterative multiply-divide unit
interface alu_mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, f3, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, f3, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - RV32M/RV64M multiply-divide unit, radix-2 shift-add multiply and restoring divide
module alu_mdu_iter #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_mdu_iter_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, is_rem, div_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     msum, dshift, ddiff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem_fix;

    always_comb begin
        is_div     = f3_q[2];
        is_rem     = f3_q[2] & f3_q[1];
        div_signed = is_div & ~f3_q[0];
        // MULHU is the only multiply with unsigned rs1; MUL and MULH treat rs2 as signed
        sa         = a_q[XLEN-1] & (is_div ? div_signed : (f3_q != 3'b011));
        sb         = b_q[XLEN-1] & (is_div ? div_signed : ~f3_q[1]);
        mag_a      = sa ? -a_q : a_q;
        mag_b      = sb ? -b_q : b_q;
        div_zero   = is_div & (b_q == '0);
        div_ovf    = div_signed & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (&b_q);

        msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        dshift = {rem_q, acc_q[XLEN-1]};
        ddiff  = dshift - {1'b0, mcand_q};

        prod    = neg_q ? -acc_q : acc_q;
        quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix = rneg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    f3_d    = bus.f3;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (div_zero) begin
                    result_d = is_rem ? a_q : '1;
                    state_d  = S_DONE;
                end else if (div_ovf) begin
                    result_d = is_rem ? '0 : a_q;
                    state_d  = S_DONE;
                end else begin
                    // multiply keeps {partial product, multiplier}; divide keeps the dividend low
                    mcand_d = is_div ? mag_b : mag_a;
                    acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                    rem_d   = '0;
                    neg_d   = (sa ^ sb) & ~is_rem;
                    rneg_d  = sa & is_rem;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div) begin
                    rem_d = ddiff[XLEN] ? dshift[XLEN-1:0] : ddiff[XLEN-1:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~ddiff[XLEN]};
                end else begin
                    acc_d = {msum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                case (f3_q)
                    3'b000:         result_d = prod[XLEN-1:0];
                    3'b100, 3'b101: result_d = quo;
                    3'b110, 3'b111: result_d = rem_fix;
                    default:        result_d = prod[2*XLEN-1:XLEN];
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_alu_mdu_iter.sv
// tb/tb_alu_mdu_iter.sv - directed self-checking bench for alu_mdu_iter at XLEN=32
module tb_alu_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   k;
    logic seen;
    logic [31:0] held;

    alu_mdu_iter_if #(.XLEN(32)) bus ();

    alu_mdu_iter #(.XLEN(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] ra, input logic [31:0] rb);
        bus.in_valid = 1'b1;
        bus.f3       = f;
        bus.a        = ra;
        bus.b        = rb;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int kk);
        kk = k0;
        while (!bus.out_valid && kk < 100) begin
            @(posedge clk);
            #1;
            kk++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [31:0] exp, input int lat);
        int kk;
        chk({tag, " in_ready"}, bus.in_ready, 1'b1);
        issue(f, ra, rb);
        wait_done(1, kk);
        chk({tag, " latency"}, kk, lat);
        chk({tag, " result"}, bus.result, exp);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " out_valid drop"}, bus.out_valid, 1'b0);
        chk({tag, " idle"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.f3        = 3'b000;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", bus.out_valid, 1'b0);
        chk("rst result", bus.result, 32'h0);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("MUL", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        run_op("MULH neg", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 35);
        run_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35);
        run_op("REM", 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35);
        run_op("DIV negb", 3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
        run_op("REM negb", 3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 35);
        run_op("DIVU", 3'b101, 32'hFFFF_FFFE, 32'h0000_0003, 32'h5555_5554, 35);
        run_op("REMU", 3'b111, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 35);
        run_op("DIV by0", 3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2);
        run_op("REMU by0", 3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // backpressure: result held while out_ready stays low
        issue(3'b101, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(1, k);
        chk("bp latency", k, 35);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp result", bus.result, 32'h5555_5554);
            chk("bp out_valid", bus.out_valid, 1'b1);
            chk("bp in_ready", bus.in_ready, 1'b0);
            chk("bp busy", bus.busy, 1'b1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp out_valid drop", bus.out_valid, 1'b0);
        chk("bp in_ready rise", bus.in_ready, 1'b1);

        // request during CALC is dropped
        issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (5) @(posedge clk);
        #1;
        chk("ign in_ready", bus.in_ready, 1'b0);
        issue(3'b101, 32'd100, 32'd7);
        wait_done(7, k);
        chk("ign latency", k, 35);
        chk("ign result", bus.result, 32'hFFFF_FFEB);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("ign no second", bus.out_valid, 1'b0);
        chk("ign idle", bus.in_ready, 1'b1);

        // flush at iteration 10
        issue(3'b001, 32'h8000_0000, 32'h8000_0000);
        repeat (11) @(posedge clk);
        #1;
        chk("fl busy before", bus.busy, 1'b1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("fl in_ready", bus.in_ready, 1'b1);
        chk("fl busy", bus.busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | bus.out_valid;
            @(posedge clk);
            #1;
        end
        chk("fl no out_valid", seen, 1'b0);

        // asynchronous reset at iteration 10
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar out_valid", bus.out_valid, 1'b0);
        chk("ar result", bus.result, 32'h0);
        chk("ar busy", bus.busy, 1'b0);
        chk("ar in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flush and out_ready together in DONE
        issue(3'b101, 32'd100, 32'd7);
        wait_done(1, k);
        chk("fd latency", k, 35);
        chk("fd result", bus.result, 32'd14);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("fd out_valid", bus.out_valid, 1'b0);
        chk("fd in_ready", bus.in_ready, 1'b1);
        chk("fd result kept", bus.result, 32'd14);
        run_op("post flush REMU", 3'b111, 32'd100, 32'd7, 32'd2, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mdu_iter.md
Name: alu_mdu_iter

Overview:
Parametrised, multi-cycle RV32M/RV64M multiply-divide unit. It sits beside the single-cycle ALU in the execute stage and is selected when the decoder sees funct7=0000001 on an OP-class instruction. funct3 is decoded internally into 8 operations, which are executed iteratively as radix-2 shift-add multiply or restoring divide. Issue and completion use valid/ready handshakes, so the core can stall on it.

Parameters:
XLEN, 32, operand and result width in bits (32 or 64).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; returns to IDLE, drops any result
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request (high only in IDLE)
f3  in  3  funct3 operation select
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 (once state is IDLE). All internal registers are cleared.
- f3 decode: 000 MUL (low XLEN bits); 001 MULH (signed×signed, high half); 010 MULHSU (signed a × unsigned b, high half); 011 MULHU (high half); 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- Accept: request is taken at a rising edge where in_valid & in_ready. a, b and f3 are latched; state goes to PREP. Requests while in_ready=0 are ignored and not queued.
- PREP, one cycle:
  - Compute sign flags and magnitudes of the signed operands.
  - Detect special divide cases:
    - divide by zero (b=0): DIV/DIVU give all-ones; REM/REMU give a.
    - signed overflow (a=-2^(XLEN-1), b=-1): DIV gives a; REM gives 0.
  - Special case: result is loaded and state goes to DONE at the next edge. out_valid is high 2 edges after the accepting edge.
  - Otherwise: state goes to CALC and the iteration counter is set to 0.
- CALC, XLEN cycles, one iteration per edge:
  - Multiply: 2·XLEN-bit accumulator; multiplier LSB selects add of the multiplicand into the upper half, then the accumulator shifts right.
  - Divide: (XLEN+1)-bit partial remainder; shift left, trial-subtract the divisor magnitude, restore on borrow, shift the quotient bit in.
  - After the XLEN-th iteration, state goes to FIX.
- FIX, one cycle:
  - Negate the product if the operand signs differ (MUL, MULH, MULHSU).
  - Negate the quotient if the dividend and divisor signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - Select the low or high half of the product, or the quotient or remainder.
  - State goes to DONE.
- Normal latency: out_valid rises XLEN+3 edges after the accepting edge (35 for XLEN=32).
- DONE:
  - out_valid=1; result is held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid goes to 0 and state goes to IDLE.
  - in_ready rises the following cycle, so back-to-back operations have a minimum 1-cycle bubble.
- flush: takes priority over every other event at the same edge, including a completing out_ready handshake. It moves to IDLE with out_valid=0; result is not cleared.
- Reset mid-operation: immediate IDLE, no output pulse.
- Width rules:
  - MUL low bits are independent of signedness.
  - All negation is two's complement modulo 2^XLEN (2^2XLEN for the product).
  - No outputs are driven combinationally from a or b.

Test Plan:
- XLEN=32, multiplies:
  - MUL 7×0xFFFFFFFD -> 0xFFFFFFEB, out_valid 35 edges after accept.
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFFE/3 -> 0x55555554.
  - REMU 0xFFFFFFFE/3 -> 0x00000002.
- Special cases, each with out_valid 2 edges after accept:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result constant, in_ready=0, busy=1. Raise out_ready -> out_valid falls next edge, in_ready=1 the cycle after.
- Busy and abort:
  - Pulse in_valid with new operands during CALC -> ignored; the first result is unchanged.
  - Assert flush at CALC iteration 10 -> IDLE next edge, no out_valid.
  - Drop rst_n at iteration 10 -> out_valid=0, result=0 immediately.
- flush and out_ready high on the same edge in DONE -> out_valid=0, IDLE. A new request issued next cycle completes correctly.
